dmem_access_unit: RTL and testbench

Load/store access unit that acts as the initiator on the data-memory port of the multicycle CPU. It accepts one load or store request at a time from the CPU control path and drives the word-wide, byte-addressed data memory (combinational read, write on rising clock edge). It performs byte and halfword loads with sign or zero extension, and implements byte and halfword stores as read-modify-write. Misaligned or illegal requests are flagged and never reach memory.

---
 rtl/dmem_access_unit.sv | 149 ++++++++++++++
 tb/tb_dmem_access_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - load/store access unit driving the word-wide data-memory port
//
// Purpose: accepts one load or store at a time from the CPU control path and
// drives a byte-addressed, word-wide data memory (combinational read, write on
// the rising clock edge). Sub-word loads are sign- or zero-extended. Sub-word
// stores are done as read-modify-write. Misaligned or illegal requests are
// flagged and never reach memory.
//
// Ports:
//   i_LSU_clk, i_LSU_rst         clock, synchronous active-high reset
//   i_LSU_req                    request strobe, sampled only in IDLE
//   i_LSU_we / i_LSU_size /
//   i_LSU_signed / i_LSU_addr /
//   i_LSU_wData                  request operands, latched at acceptance
//   o_LSU_busy                   high whenever the unit is not IDLE
//   o_LSU_done / o_LSU_err       one-cycle completion pulse and its error flag
//   o_LSU_rData                  load result, held until the next load completes
//   o_DMem_we / o_DMem_addr /
//   o_DMem_wData / i_DMem_rData  data-memory port

module dmem_access_unit (
  input  logic        i_LSU_clk,
  input  logic        i_LSU_rst,
  input  logic        i_LSU_req,
  input  logic        i_LSU_we,
  input  logic [1:0]  i_LSU_size,
  input  logic        i_LSU_signed,
  input  logic [31:0] i_LSU_addr,
  input  logic [31:0] i_LSU_wData,
  output logic        o_LSU_busy,
  output logic        o_LSU_done,
  output logic [31:0] o_LSU_rData,
  output logic        o_LSU_err,
  output logic        o_DMem_we,
  output logic [31:0] o_DMem_addr,
  output logic [31:0] o_DMem_wData,
  input  logic [31:0] i_DMem_rData
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_err;
  logic [31:0] rd_word_q;

  logic        req_err;
  logic [31:0] lane_shifted;
  logic [31:0] load_val;
  logic [31:0] merge_word;

  assign req_err = (i_LSU_size == 2'b11)
                 || ((i_LSU_size == 2'b01) && i_LSU_addr[0])
                 || ((i_LSU_size == 2'b10) && (i_LSU_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_LSU_req) begin
          if (req_err)
            state_d = S_DONE;
          else if (i_LSU_we && (i_LSU_size == 2'b10))
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD:    state_d = lat_we ? S_WR : S_DONE;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A legal halfword has addr[0]=0, so one byte-granular shift serves
  // both byte and halfword lane selection.
  always_comb begin
    lane_shifted = i_DMem_rData >> {lat_addr[1:0], 3'b000};
    case (lat_size)
      2'b00:   load_val = lat_signed ? {{24{lane_shifted[7]}},  lane_shifted[7:0]}
                                     : {24'h000000, lane_shifted[7:0]};
      2'b01:   load_val = lat_signed ? {{16{lane_shifted[15]}}, lane_shifted[15:0]}
                                     : {16'h0000, lane_shifted[15:0]};
      default: load_val = i_DMem_rData;
    endcase
  end

  // Write data for WR: the word read during RD with the addressed lanes
  // replaced, or the latched store data outright for a word store.
  always_comb begin
    merge_word = rd_word_q;
    case (lat_size)
      2'b00:   merge_word[{lat_addr[1:0], 3'b000} +: 8]  = lat_wdata[7:0];
      2'b01:   merge_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
      default: merge_word = lat_wdata;
    endcase
  end

  assign o_LSU_busy   = (state_q != S_IDLE);
  assign o_LSU_done   = (state_q == S_DONE);
  assign o_LSU_err    = (state_q == S_DONE) && lat_err;
  assign o_DMem_we    = (state_q == S_WR);
  assign o_DMem_addr  = ((state_q == S_RD) || (state_q == S_WR)) ? {lat_addr[31:2], 2'b00} : 32'h0;
  assign o_DMem_wData = (state_q == S_WR) ? merge_word : 32'h0;

  always_ff @(posedge i_LSU_clk) begin
    if (i_LSU_rst) begin
      state_q     <= S_IDLE;
      lat_we      <= 1'b0;
      lat_size    <= 2'b00;
      lat_signed  <= 1'b0;
      lat_addr    <= 32'h0;
      lat_wdata   <= 32'h0;
      lat_err     <= 1'b0;
      rd_word_q   <= 32'h0;
      o_LSU_rData <= 32'h0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && i_LSU_req) begin
        lat_we     <= i_LSU_we;
        lat_size   <= i_LSU_size;
        lat_signed <= i_LSU_signed;
        lat_addr   <= i_LSU_addr;
        lat_wdata  <= i_LSU_wData;
        lat_err    <= req_err;
      end
      // Register the load result on the edge into DONE so it is valid
      // during the done pulse itself.
      if (state_q == S_RD) begin
        rd_word_q <= i_DMem_rData;
        if (!lat_we)
          o_LSU_rData <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - self-checking bench for dmem_access_unit

module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sgn = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err, dm_we;
  logic [31:0] rdata, dm_addr, dm_wdata, dm_rdata;

  dmem_access_unit dut (
    .i_LSU_clk(clk), .i_LSU_rst(rst), .i_LSU_req(req), .i_LSU_we(we),
    .i_LSU_size(size), .i_LSU_signed(sgn), .i_LSU_addr(addr), .i_LSU_wData(wdata),
    .o_LSU_busy(busy), .o_LSU_done(done), .o_LSU_rData(rdata), .o_LSU_err(err),
    .o_DMem_we(dm_we), .o_DMem_addr(dm_addr), .o_DMem_wData(dm_wdata),
    .i_DMem_rData(dm_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: 64 words, combinational read, write on the rising edge.
  logic [31:0] mem [64];
  logic        mem_clr = 1'b1;
  assign dm_rdata = mem[dm_addr[7:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (dm_we) begin
      mem[dm_addr[7:2]] <= dm_wdata;
    end
  end

  int          we_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] last_waddr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  always @(negedge clk) begin
    if (dm_we) begin
      we_cnt     <= we_cnt + 1;
      last_waddr <= dm_addr;
      last_wdata <= dm_wdata;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a flat byte array and the last load result.
  logic [7:0]  ref_mem [256];
  logic [31:0] ref_hold = 32'h0;

  task automatic ref_apply(input logic r_we, input logic [1:0] r_sz, input logic r_sg,
                           input logic [31:0] r_a, input logic [31:0] r_wd,
                           output logic e_err, output int e_lat, output int e_nwe,
                           output logic [31:0] e_rd, output logic [31:0] e_wdo);
    int nb;
    int base;
    logic [31:0] v;
    nb    = 1 << r_sz;
    base  = int'(r_a[7:0]);
    e_err = (r_sz == 2'd3) || (r_sz == 2'd1 && r_a[0]) || (r_sz == 2'd2 && r_a[1:0] != 2'd0);
    e_wdo = 32'h0;
    if (e_err) begin
      e_lat = 1;
      e_nwe = 0;
    end else if (r_we) begin
      for (int k = 0; k < nb; k++) ref_mem[base + k] = r_wd[8*k +: 8];
      e_lat = (nb == 4) ? 2 : 3;
      e_nwe = 1;
      for (int k = 0; k < 4; k++) e_wdo[8*k +: 8] = ref_mem[(base & 252) + k];
    end else begin
      v = 32'h0;
      for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[base + k];
      if (r_sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
      ref_hold = v;
      e_lat = 2;
      e_nwe = 0;
    end
    e_rd = ref_hold;
  endtask

  // One request: returns latency (edges from acceptance to the done cycle),
  // the done-cycle err/rData, number of write pulses, and the written word/address.
  task automatic do_op(input logic o_we, input logic [1:0] o_sz, input logic o_sg,
                       input logic [31:0] o_a, input logic [31:0] o_wd,
                       output int lat, output logic o_err, output logic [31:0] o_rd,
                       output int nwe, output logic [31:0] wdo, output logic [31:0] wad);
    int we0;
    we0 = we_cnt;
    @(negedge clk);
    req = 1'b1; we = o_we; size = o_sz; sgn = o_sg; addr = o_a; wdata = o_wd;
    @(posedge clk);
    #1;
    req = 1'b0; we = $urandom; size = 2'($urandom); sgn = $urandom;
    addr = $urandom; wdata = $urandom;
    lat = 1;
    @(negedge clk);
    chk("busy_after_accept", {31'h0, busy}, 32'h1);
    while (done !== 1'b1 && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 8) chk("done_timeout", 32'h0, 32'h1);
    o_err = err;
    o_rd  = rdata;
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_done", {31'h0, busy}, 32'h0);
    nwe = we_cnt - we0;
    wdo = last_wdata;
    wad = last_waddr;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic        e_err;
    int          e_lat;
    int          e_nwe;
    logic [31:0] e_rd;
    logic [31:0] e_wdo;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int          lat, nwe, e_lat, e_nwe, d0, w0;
    logic        o_err, e_err;
    logic [31:0] o_rd, wdo, wad, e_rd, e_wdo;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 2, 1, 32'h00000000, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h00000000, 1'b0, 2, 0, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0, 2, 1, 32'hDEADBEEF, 32'h11223344};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, 1'b0, 3, 1, 32'hDEADBEEF, 32'h1122AB44};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h00000000, 1'b0, 2, 0, 32'h1122AB44, 32'h0};
    tbl[5]  = '{1'b1, 2'd0, 1'b0, 32'h22, 32'hFFFFFF80, 1'b0, 3, 1, 32'h1122AB44, 32'h00800000};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 32'h22, 32'h00000000, 1'b0, 2, 0, 32'hFFFFFF80, 32'h0};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 32'h22, 32'h00000000, 1'b0, 2, 0, 32'h00000080, 32'h0};
    tbl[8]  = '{1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD8001, 1'b0, 3, 1, 32'h00000080, 32'h80010000};
    tbl[9]  = '{1'b0, 2'd1, 1'b1, 32'h22, 32'h00000000, 1'b0, 2, 0, 32'hFFFF8001, 32'h0};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h13, 32'h12345678, 1'b1, 1, 0, 32'hFFFF8001, 32'h0};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h12, 32'h00000000, 1'b1, 1, 0, 32'hFFFF8001, 32'h0};
    tbl[12] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h00000000, 1'b1, 1, 0, 32'hFFFF8001, 32'h0};
    tbl[13] = '{1'b0, 2'd1, 1'b0, 32'h22, 32'h00000000, 1'b0, 2, 0, 32'h00008001, 32'h0};
    tbl[14] = '{1'b0, 2'd0, 1'b1, 32'h23, 32'h00000000, 1'b0, 2, 0, 32'hFFFFFF80, 32'h0};

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_dm_we", {31'h0, dm_we}, 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      ref_apply(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, e_err, e_lat, e_nwe, e_rd, e_wdo);
      do_op(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, lat, o_err, o_rd, nwe, wdo, wad);
      chk($sformatf("tbl%0d_err", i), {31'h0, o_err}, {31'h0, tbl[i].e_err});
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].e_lat);
      chk($sformatf("tbl%0d_nwe", i), nwe, tbl[i].e_nwe);
      chk($sformatf("tbl%0d_rdata", i), o_rd, tbl[i].e_rd);
      if (tbl[i].e_nwe == 1) begin
        chk($sformatf("tbl%0d_wdata", i), wdo, tbl[i].e_wdo);
        chk($sformatf("tbl%0d_waddr", i), wad, {tbl[i].a[31:2], 2'b00});
      end
    end

    // Busy protocol: req and operands toggled during RD and WR of a byte store
    ref_apply(1'b1, 2'd0, 1'b0, 32'h31, 32'h0000005A, e_err, e_lat, e_nwe, e_rd, e_wdo);
    d0 = done_cnt;
    w0 = we_cnt;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; sgn = 1'b0; addr = 32'h31; wdata = 32'h0000005A;
    @(posedge clk);
    #1;
    we = 1'b0; size = 2'd2; addr = 32'h10; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("busy_rd_addr", dm_addr, 32'h30);
    @(posedge clk);
    #1;
    req = 1'b0;
    #2;
    req = 1'b1;
    @(negedge clk);
    chk("busy_wr_we", {31'h0, dm_we}, 32'h1);
    chk("busy_wr_wdata", dm_wdata, 32'h00005A00);
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    chk("busy_done", {31'h0, done}, 32'h1);
    repeat (4) @(negedge clk);
    chk("busy_done_count", done_cnt - d0, 32'd1);
    chk("busy_we_count", we_cnt - w0, 32'd1);

    // Reset during RD of a byte store
    d0 = done_cnt;
    w0 = we_cnt;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; sgn = 1'b0; addr = 32'h41; wdata = 32'h00000077;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    chk("rstmid_rd_addr", dm_addr, 32'h40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    chk("rstmid_rdata", rdata, 32'h0);
    chk("rstmid_dm", {dm_addr[30:0], dm_we} | dm_wdata | {31'h0, done | err}, 32'h0);
    ref_hold = 32'h0;
    repeat (4) @(negedge clk);
    chk("rstmid_no_done", done_cnt - d0, 32'd0);
    chk("rstmid_no_we", we_cnt - w0, 32'd0);
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, o_err, o_rd, nwe, wdo, wad);
    ref_apply(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_err, e_lat, e_nwe, e_rd, e_wdo);
    chk("post_rst_load", o_rd, 32'h1122AB44);
    chk("post_rst_lat", lat, 32'd2);
    do_op(1'b0, 2'd0, 1'b0, 32'h31, 32'h0, lat, o_err, o_rd, nwe, wdo, wad);
    ref_apply(1'b0, 2'd0, 1'b0, 32'h31, 32'h0, e_err, e_lat, e_nwe, e_rd, e_wdo);
    chk("busy_store_readback", o_rd, 32'h0000005A);

    // Randomized operations against the reference model
    for (int n = 0; n < 150; n++) begin
      logic        r_we, r_sg;
      logic [1:0]  r_sz;
      logic [31:0] r_a, r_wd;
      r_we = $urandom;
      r_sg = $urandom;
      r_sz = 2'($urandom_range(0, 3));
      r_a  = 32'($urandom_range(0, 255));
      r_wd = $urandom;
      ref_apply(r_we, r_sz, r_sg, r_a, r_wd, e_err, e_lat, e_nwe, e_rd, e_wdo);
      do_op(r_we, r_sz, r_sg, r_a, r_wd, lat, o_err, o_rd, nwe, wdo, wad);
      chk($sformatf("rnd%0d_err", n), {31'h0, o_err}, {31'h0, e_err});
      chk($sformatf("rnd%0d_lat", n), lat, e_lat);
      chk($sformatf("rnd%0d_nwe", n), nwe, e_nwe);
      chk($sformatf("rnd%0d_rdata", n), o_rd, e_rd);
      if (e_nwe == 1) begin
        chk($sformatf("rnd%0d_wdata", n), wdo, e_wdo);
        chk($sformatf("rnd%0d_waddr", n), wad, {r_a[31:2], 2'b00});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
